// File: rtl/axi_rd_arbiter.sv
// AXI3 read arbiter: funnels NM cache read masters onto a single read port,
// one outstanding burst at a time, with sticky length and watchdog error flags.
module axi_rd_arbiter #(
    parameter int unsigned NM      = 2,
    parameter int unsigned RR      = 0,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic             aclk,
    input  logic             areset,
    // Master-side AR channels, master i at slice i
    input  logic [NM*4-1:0]  m_arid,
    input  logic [NM*32-1:0] m_araddr,
    input  logic [NM*8-1:0]  m_arlen,
    input  logic [NM*3-1:0]  m_arsize,
    input  logic [NM*2-1:0]  m_arburst,
    input  logic [NM-1:0]    m_arvalid,
    output logic [NM-1:0]    m_arready,
    // Master-side R channel, payload broadcast, valid/ready per master
    output logic [3:0]       m_rid,
    output logic [31:0]      m_rdata,
    output logic [1:0]       m_rresp,
    output logic             m_rlast,
    output logic [NM-1:0]    m_rvalid,
    input  logic [NM-1:0]    m_rready,
    // Slave-side AR channel
    output logic [3:0]       s_arid,
    output logic [31:0]      s_araddr,
    output logic [7:0]       s_arlen,
    output logic [2:0]       s_arsize,
    output logic [1:0]       s_arburst,
    output logic             s_arvalid,
    input  logic             s_arready,
    // Slave-side R channel
    input  logic [3:0]       s_rid,
    input  logic [31:0]      s_rdata,
    input  logic [1:0]       s_rresp,
    input  logic             s_rlast,
    input  logic             s_rvalid,
    output logic             s_rready,
    // Status
    output logic             busy,
    output logic [1:0]       grant,
    output logic             err_len,
    output logic             err_timeout
);

    localparam int unsigned WdW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAddr = 2'd1,
        StData = 2'd2
    } state_e;

    state_e       state_q, state_d;
    logic [3:0]   arid_q, arid_d;
    logic [31:0]  araddr_q, araddr_d;
    logic [7:0]   arlen_q, arlen_d;
    logic [2:0]   arsize_q, arsize_d;
    logic [1:0]   arburst_q, arburst_d;
    logic [1:0]   grant_q, grant_d;
    logic [1:0]   rr_ptr_q, rr_ptr_d;
    logic [8:0]   beat_q, beat_d;
    logic [WdW-1:0] wdog_q, wdog_d;
    logic         err_len_q, err_len_d;
    logic         err_timeout_q, err_timeout_d;

    logic         req_any;
    logic [1:0]   win_idx;
    int           win_int;
    logic         r_hs;
    logic         progress;

    // Pick the winning requester according to the configured policy
    always_comb begin
        req_any = |m_arvalid;
        win_idx = '0;
        if (RR == 0) begin
            // Ascending scan: last hit is the highest requesting index
            for (int i = 0; i < int'(NM); i++) begin
                if (m_arvalid[i]) begin
                    win_idx = 2'(i);
                end
            end
        end else begin
            // Descending distance scan: last hit is the first index after the pointer
            for (int k = int'(NM); k >= 1; k--) begin
                int idx;
                idx = (int'(rr_ptr_q) + k) % int'(NM);
                if (m_arvalid[idx]) begin
                    win_idx = 2'(idx);
                end
            end
        end
        win_int = int'(win_idx);
    end

    // Next-state, request capture, beat accounting, watchdog and handshake outputs
    always_comb begin
        state_d       = state_q;
        arid_d        = arid_q;
        araddr_d      = araddr_q;
        arlen_d       = arlen_q;
        arsize_d      = arsize_q;
        arburst_d     = arburst_q;
        grant_d       = grant_q;
        rr_ptr_d      = rr_ptr_q;
        beat_d        = beat_q;
        wdog_d        = wdog_q;
        err_len_d     = err_len_q;
        err_timeout_d = err_timeout_q;
        m_arready     = '0;
        m_rvalid      = '0;
        s_rready      = 1'b0;
        r_hs          = 1'b0;
        progress      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req_any) begin
                    m_arready[win_idx] = 1'b1;
                    arid_d    = m_arid[win_int*4 +: 4];
                    araddr_d  = m_araddr[win_int*32 +: 32];
                    arlen_d   = m_arlen[win_int*8 +: 8];
                    arsize_d  = m_arsize[win_int*3 +: 3];
                    arburst_d = m_arburst[win_int*2 +: 2];
                    grant_d   = win_idx;
                    rr_ptr_d  = win_idx;
                    beat_d    = '0;
                    state_d   = StAddr;
                end
            end
            StAddr: begin
                if (s_arready) begin
                    progress = 1'b1;
                    state_d  = StData;
                end
            end
            StData: begin
                m_rvalid[grant_q] = s_rvalid;
                s_rready          = m_rready[grant_q];
                r_hs              = s_rvalid & m_rready[grant_q];
                if (r_hs) begin
                    progress = 1'b1;
                    beat_d   = beat_q + 9'd1;
                    // Last flagged at the wrong beat, or absent at the expected one
                    if (s_rlast && (beat_q != {1'b0, arlen_q})) begin
                        err_len_d = 1'b1;
                    end
                    if (!s_rlast && (beat_q == {1'b0, arlen_q})) begin
                        err_len_d = 1'b1;
                    end
                    if (s_rlast) begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Watchdog runs only while a transaction is in flight; saturates at TIMEOUT
        if (state_q == StIdle || state_d == StIdle || progress) begin
            wdog_d = '0;
        end else begin
            if (wdog_q != WdW'(TIMEOUT)) begin
                wdog_d = wdog_q + 1'b1;
            end
            if (wdog_d == WdW'(TIMEOUT)) begin
                err_timeout_d = 1'b1;
            end
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q       <= StIdle;
            arid_q        <= '0;
            araddr_q      <= '0;
            arlen_q       <= '0;
            arsize_q      <= '0;
            arburst_q     <= '0;
            grant_q       <= '0;
            rr_ptr_q      <= 2'(NM - 1);
            beat_q        <= '0;
            wdog_q        <= '0;
            err_len_q     <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            arid_q        <= arid_d;
            araddr_q      <= araddr_d;
            arlen_q       <= arlen_d;
            arsize_q      <= arsize_d;
            arburst_q     <= arburst_d;
            grant_q       <= grant_d;
            rr_ptr_q      <= rr_ptr_d;
            beat_q        <= beat_d;
            wdog_q        <= wdog_d;
            err_len_q     <= err_len_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    // Registered AR fields, zero-latency R payload pass-through, status
    always_comb begin
        s_arid      = arid_q;
        s_araddr    = araddr_q;
        s_arlen     = arlen_q;
        s_arsize    = arsize_q;
        s_arburst   = arburst_q;
        s_arvalid   = (state_q == StAddr);
        m_rid       = s_rid;
        m_rdata     = s_rdata;
        m_rresp     = s_rresp;
        m_rlast     = s_rlast;
        busy        = (state_q != StIdle);
        grant       = grant_q;
        err_len     = err_len_q;
        err_timeout = err_timeout_q;
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench: a fixed-priority and a round-robin instance share all inputs.
module tb_axi_rd_arbiter;

    logic        aclk = 1'b0;
    logic        areset;
    logic [7:0]  m_arid;
    logic [63:0] m_araddr;
    logic [15:0] m_arlen;
    logic [5:0]  m_arsize;
    logic [3:0]  m_arburst;
    logic [1:0]  m_arvalid;
    logic [1:0]  m_rready;
    logic        s_arready;
    logic [3:0]  s_rid;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rlast;
    logic        s_rvalid;

    // Outputs of fixed-priority instance (f_) and round-robin instance (r_)
    logic [1:0]  f_m_arready, r_m_arready;
    logic [3:0]  f_m_rid, r_m_rid;
    logic [31:0] f_m_rdata, r_m_rdata;
    logic [1:0]  f_m_rresp, r_m_rresp;
    logic        f_m_rlast, r_m_rlast;
    logic [1:0]  f_m_rvalid, r_m_rvalid;
    logic [3:0]  f_s_arid, r_s_arid;
    logic [31:0] f_s_araddr, r_s_araddr;
    logic [7:0]  f_s_arlen, r_s_arlen;
    logic [2:0]  f_s_arsize, r_s_arsize;
    logic [1:0]  f_s_arburst, r_s_arburst;
    logic        f_s_arvalid, r_s_arvalid;
    logic        f_s_rready, r_s_rready;
    logic        f_busy, r_busy;
    logic [1:0]  f_grant, r_grant;
    logic        f_err_len, r_err_len;
    logic        f_err_timeout, r_err_timeout;

    int total = 0;
    int bad   = 0;

    always #5 aclk = ~aclk;

    axi_rd_arbiter #(.NM(2), .RR(0), .TIMEOUT(16)) u_fix (
        .aclk(aclk), .areset(areset),
        .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(f_m_arready),
        .m_rid(f_m_rid), .m_rdata(f_m_rdata), .m_rresp(f_m_rresp), .m_rlast(f_m_rlast),
        .m_rvalid(f_m_rvalid), .m_rready(m_rready),
        .s_arid(f_s_arid), .s_araddr(f_s_araddr), .s_arlen(f_s_arlen),
        .s_arsize(f_s_arsize), .s_arburst(f_s_arburst), .s_arvalid(f_s_arvalid),
        .s_arready(s_arready),
        .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .s_rvalid(s_rvalid), .s_rready(f_s_rready),
        .busy(f_busy), .grant(f_grant), .err_len(f_err_len), .err_timeout(f_err_timeout)
    );

    axi_rd_arbiter #(.NM(2), .RR(1), .TIMEOUT(16)) u_rr (
        .aclk(aclk), .areset(areset),
        .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(r_m_arready),
        .m_rid(r_m_rid), .m_rdata(r_m_rdata), .m_rresp(r_m_rresp), .m_rlast(r_m_rlast),
        .m_rvalid(r_m_rvalid), .m_rready(m_rready),
        .s_arid(r_s_arid), .s_araddr(r_s_araddr), .s_arlen(r_s_arlen),
        .s_arsize(r_s_arsize), .s_arburst(r_s_arburst), .s_arvalid(r_s_arvalid),
        .s_arready(s_arready),
        .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .s_rvalid(s_rvalid), .s_rready(r_s_rready),
        .busy(r_busy), .grant(r_grant), .err_len(r_err_len), .err_timeout(r_err_timeout)
    );

    typedef struct {
        logic [1:0]  arvalid;
        logic [1:0]  f_rdy;
        logic [1:0]  r_rdy;
        logic        busy;
        logic [1:0]  f_gnt;
        logic [1:0]  r_gnt;
        logic [31:0] f_addr;
        logic [31:0] r_addr;
        logic [7:0]  f_len;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_reset();
        areset    = 1'b1;
        m_arvalid = 2'b00;
        s_arready = 1'b0;
        s_rvalid  = 1'b0;
        s_rlast   = 1'b0;
        cyc();
        areset = 1'b0;
    endtask

    initial begin
        // Master 0: icache, master 1: dcache
        m_arid    = {4'hA, 4'h3};
        m_araddr  = {32'h1FC0_0100, 32'h0000_1000};
        m_arlen   = {8'd3, 8'd0};
        m_arsize  = {3'd2, 3'd2};
        m_arburst = {2'd1, 2'd1};
        m_rready  = 2'b11;
        s_rid     = 4'hA;
        s_rdata   = '0;
        s_rresp   = 2'b00;

        // arvalid, f_rdy, r_rdy, busy, f_gnt, r_gnt, f_addr, r_addr, f_len
        vecs[0] = '{2'b00, 2'b00, 2'b00, 1'b0, 2'd0, 2'd0, 32'h0, 32'h0, 8'd0};
        vecs[1] = '{2'b01, 2'b01, 2'b01, 1'b1, 2'd0, 2'd0, 32'h0000_1000, 32'h0000_1000, 8'd0};
        vecs[2] = '{2'b10, 2'b10, 2'b10, 1'b1, 2'd1, 2'd1, 32'h1FC0_0100, 32'h1FC0_0100, 8'd3};
        vecs[3] = '{2'b11, 2'b10, 2'b01, 1'b1, 2'd1, 2'd0, 32'h1FC0_0100, 32'h0000_1000, 8'd3};

        // Reset state
        do_reset();
        #1;
        chk("rst_busy", 64'(f_busy), 64'd0);
        chk("rst_arready", 64'(f_m_arready), 64'd0);
        chk("rst_s_arvalid", 64'(f_s_arvalid), 64'd0);
        chk("rst_s_rready", 64'(f_s_rready), 64'd0);
        chk("rst_rvalid", 64'(f_m_rvalid), 64'd0);
        chk("rst_grant", 64'(f_grant), 64'd0);
        chk("rst_errs", 64'({f_err_len, f_err_timeout}), 64'd0);
        chk("rst_s_araddr", 64'(f_s_araddr), 64'd0);

        // Arbitration table from a fresh reset
        for (int v = 0; v < 4; v++) begin
            do_reset();
            m_arvalid = vecs[v].arvalid;
            #1;
            chk($sformatf("v%0d_f_arready", v), 64'(f_m_arready), 64'(vecs[v].f_rdy));
            chk($sformatf("v%0d_r_arready", v), 64'(r_m_arready), 64'(vecs[v].r_rdy));
            cyc();
            chk($sformatf("v%0d_busy", v), 64'(f_busy), 64'(vecs[v].busy));
            chk($sformatf("v%0d_s_arvalid", v), 64'(f_s_arvalid), 64'(vecs[v].busy));
            chk($sformatf("v%0d_f_grant", v), 64'(f_grant), 64'(vecs[v].f_gnt));
            chk($sformatf("v%0d_r_grant", v), 64'(r_grant), 64'(vecs[v].r_gnt));
            chk($sformatf("v%0d_f_addr", v), 64'(f_s_araddr), 64'(vecs[v].f_addr));
            chk($sformatf("v%0d_r_addr", v), 64'(r_s_araddr), 64'(vecs[v].r_addr));
            chk($sformatf("v%0d_f_len", v), 64'(f_s_arlen), 64'(vecs[v].f_len));
            chk($sformatf("v%0d_addr_arready", v), 64'(f_m_arready), 64'd0);
        end

        // Round robin: continuous requests, single-beat bursts, 3 cycles per burst
        do_reset();
        m_arlen   = {8'd0, 8'd0};
        m_arvalid = 2'b11;
        s_arready = 1'b1;
        s_rvalid  = 1'b1;
        s_rlast   = 1'b1;
        m_rready  = 2'b11;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (c % 3 == 0) begin
                chk($sformatf("rr_c%0d_arready", c), 64'(r_m_arready),
                    ((c / 3) % 2 == 0) ? 64'd1 : 64'd2);
                chk($sformatf("fp_c%0d_arready", c), 64'(f_m_arready), 64'd2);
            end else begin
                chk($sformatf("rr_c%0d_arready", c), 64'(r_m_arready), 64'd0);
                chk($sformatf("fp_c%0d_arready", c), 64'(f_m_arready), 64'd0);
            end
            if (c % 3 == 1) begin
                chk($sformatf("rr_c%0d_grant", c), 64'(r_grant), 64'((c / 3) % 2));
            end
            cyc();
        end
        chk("rr_err_len", 64'({r_err_len, f_err_len}), 64'd0);
        m_arlen = {8'd3, 8'd0};

        // Slave stalls AR for 5 cycles, then len=3 burst with master backpressure on beat 2
        do_reset();
        s_rvalid  = 1'b0;
        s_rlast   = 1'b0;
        m_arvalid = 2'b10;
        cyc();
        m_arvalid = 2'b01;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk($sformatf("stall%0d_s_arvalid", c), 64'(f_s_arvalid), 64'd1);
            chk($sformatf("stall%0d_addr", c), 64'(f_s_araddr), 64'h1FC0_0100);
            chk($sformatf("stall%0d_id", c), 64'({f_s_arid, f_s_arlen}), 64'hA03);
            chk($sformatf("stall%0d_arready", c), 64'({f_m_arready, r_m_arready}), 64'd0);
            cyc();
        end
        s_arready = 1'b1;
        cyc();
        s_arready = 1'b0;
        #1;
        chk("data_entry_s_arvalid", 64'(f_s_arvalid), 64'd0);
        chk("data_entry_busy", 64'(f_busy), 64'd1);
        for (int k = 0; k < 4; k++) begin
            s_rvalid = 1'b1;
            s_rdata  = 32'hD000_0000 + 32'(k);
            s_rlast  = (k == 3);
            if (k == 2) begin
                m_rready = 2'b01;
                for (int w = 0; w < 3; w++) begin
                    #1;
                    chk($sformatf("bp%0d_s_rready", w), 64'(f_s_rready), 64'd0);
                    chk($sformatf("bp%0d_rvalid", w), 64'(f_m_rvalid), 64'd2);
                    cyc();
                end
                m_rready = 2'b11;
            end
            #1;
            chk($sformatf("beat%0d_s_rready", k), 64'(f_s_rready), 64'd1);
            chk($sformatf("beat%0d_rvalid", k), 64'({f_m_rvalid, r_m_rvalid}), 64'hA);
            chk($sformatf("beat%0d_rdata", k), 64'(f_m_rdata), 64'(32'hD000_0000 + 32'(k)));
            chk($sformatf("beat%0d_rlast", k), 64'(f_m_rlast), 64'(k == 3));
            cyc();
        end
        s_rvalid = 1'b0;
        s_rlast  = 1'b0;
        #1;
        chk("burst_done_busy", 64'(f_busy), 64'd0);
        chk("burst_done_err_len", 64'(f_err_len), 64'd0);
        chk("next_grant_arready", 64'({f_m_arready, r_m_arready}), 64'h5);

        // Early rlast on beat 1 of a len=3 burst; flag stays set across a clean burst
        do_reset();
        m_arvalid = 2'b10;
        cyc();
        m_arvalid = 2'b00;
        s_arready = 1'b1;
        cyc();
        s_arready = 1'b0;
        s_rvalid  = 1'b1;
        s_rlast   = 1'b0;
        #1;
        chk("early_beat0_err_len", 64'(f_err_len), 64'd0);
        cyc();
        s_rlast = 1'b1;
        cyc();
        s_rvalid = 1'b0;
        s_rlast  = 1'b0;
        #1;
        chk("early_err_len", 64'(f_err_len), 64'd1);
        chk("early_busy", 64'(f_busy), 64'd0);
        m_arvalid = 2'b01;
        cyc();
        m_arvalid = 2'b00;
        s_arready = 1'b1;
        cyc();
        s_arready = 1'b0;
        s_rvalid  = 1'b1;
        s_rlast   = 1'b1;
        cyc();
        s_rvalid = 1'b0;
        s_rlast  = 1'b0;
        #1;
        chk("clean_busy", 64'(f_busy), 64'd0);
        chk("sticky_err_len", 64'(f_err_len), 64'd1);

        // Missing rlast on the final beat of a single-beat burst
        do_reset();
        #1;
        chk("rst_clears_err_len", 64'(f_err_len), 64'd0);
        m_arvalid = 2'b01;
        cyc();
        m_arvalid = 2'b00;
        s_arready = 1'b1;
        cyc();
        s_arready = 1'b0;
        s_rvalid  = 1'b1;
        s_rlast   = 1'b0;
        cyc();
        s_rvalid = 1'b0;
        #1;
        chk("missing_last_err_len", 64'(f_err_len), 64'd1);
        chk("missing_last_busy", 64'(f_busy), 64'd1);

        // Watchdog: slave never answers in DATA, then reset mid-burst
        do_reset();
        m_arvalid = 2'b10;
        cyc();
        m_arvalid = 2'b00;
        s_arready = 1'b1;
        cyc();
        s_arready = 1'b0;
        for (int c = 0; c < 15; c++) begin
            cyc();
        end
        chk("wdog15_err_timeout", 64'(f_err_timeout), 64'd0);
        cyc();
        chk("wdog16_err_timeout", 64'({f_err_timeout, r_err_timeout}), 64'h3);
        chk("wdog16_busy", 64'(f_busy), 64'd1);
        do_reset();
        #1;
        chk("midrst_busy", 64'(f_busy), 64'd0);
        chk("midrst_errs", 64'({f_err_len, f_err_timeout}), 64'd0);
        chk("midrst_hs", 64'({f_m_arready, f_m_rvalid, f_s_arvalid, f_s_rready}), 64'd0);
        chk("midrst_grant", 64'(f_grant), 64'd0);
        chk("midrst_s_ar", 64'({f_s_araddr, f_s_arlen, f_s_arid}), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
Arbitrates AXI3 read-address/read-data traffic from NM cache masters (master 0 = icache, master 1 = dcache) onto the single CPU read port.
- Sits between the cache AXI masters and the top-level AXI read channels.
- Allows one outstanding read burst at a time.
- Checks burst length and slave responsiveness, and reports violations as sticky error flags.

Parameters:
NM, 2, number of read masters (2..4)
RR, 0, arbitration policy: 0 = fixed priority, highest index wins; 1 = round robin
TIMEOUT, 1024, max cycles in ADDR/DATA without a handshake before err_timeout is set

Ports:
aclk  in  1  clock
areset  in  1  synchronous active-high reset
m_arid  in  NM*4  per-master AR id, master i at [4i+:4]
m_araddr  in  NM*32  per-master AR address
m_arlen  in  NM*8  per-master burst length minus 1
m_arsize  in  NM*3  per-master beat size
m_arburst  in  NM*2  per-master burst type
m_arvalid  in  NM  per-master AR valid
m_arready  out  NM  per-master AR ready
m_rid  out  4  R id, broadcast to all masters
m_rdata  out  32  R data, broadcast
m_rresp  out  2  R response, broadcast
m_rlast  out  1  R last, broadcast
m_rvalid  out  NM  per-master R valid
m_rready  in  NM  per-master R ready
s_arid  out  4  slave AR id
s_araddr  out  32  slave AR address
s_arlen  out  8  slave AR length
s_arsize  out  3  slave AR size
s_arburst  out  2  slave AR burst
s_arvalid  out  1  slave AR valid
s_arready  in  1  slave AR ready
s_rid  in  4  slave R id
s_rdata  in  32  slave R data
s_rresp  in  2  slave R response
s_rlast  in  1  slave R last
s_rvalid  in  1  slave R valid
s_rready  out  1  slave R ready
busy  out  1  high whenever state != IDLE
grant  out  2  index of the current/last granted master
err_len  out  1  sticky: rlast early or missing at the expected beat
err_timeout  out  1  sticky: TIMEOUT cycles without progress

Behaviour:
- Clock is aclk. Reset is synchronous and active-high, on areset.
- Reset values:
  - State IDLE; all m_arready, m_rvalid, s_arvalid, s_rready = 0.
  - s_ar* fields = 0; grant = 0; err_* = 0; beat counter and watchdog = 0.
  - Round-robin pointer = NM-1, so master 0 wins first under RR.
- Reset mid-burst abandons the transaction and returns to IDLE. The slave is not drained; system-wide reset is the assumption of use.

- IDLE:
  - If any m_arvalid is set, select a winner:
    - RR=0: highest index with arvalid set.
    - RR=1: first index with arvalid set after the pointer, wrapping modulo NM.
  - m_arready[winner] = 1 combinationally in that cycle; all other m_arready = 0.
  - On the clock edge: latch the winner's id/addr/len/size/burst into the s_ar* registers, set grant = winner, update the RR pointer to winner, set beat counter = 0, go to ADDR.
  - No m_arvalid: stay in IDLE; m_arready all 0.
- ADDR:
  - s_arvalid = 1; s_ar* are held stable from registers.
  - m_arready stays 0 for every master.
  - On s_arready: go to DATA.
- DATA:
  - Data path: m_rvalid[grant] = s_rvalid, other m_rvalid = 0. s_rready = m_rready[grant]. m_rid/rdata/rresp/rlast = s_r* (pass-through, 0 added latency).
  - Each s_rvalid & s_rready increments the beat counter (9-bit).
  - Length check on each accepted beat:
    - s_rlast=1 with beat counter != latched arlen → set err_len.
    - Beat counter == arlen with s_rlast=0 → set err_len.
  - An accepted beat with s_rlast=1 returns to IDLE. Minimum one bubble cycle before the next AR grant.
  - s_rid is not compared; it is forwarded unchanged.
- Watchdog:
  - Counts cycles in ADDR/DATA; cleared on any AR or R handshake and on entry to IDLE.
  - Reaching TIMEOUT sets err_timeout. The state does not change.
- err_* clear only on reset.
- Simultaneous requests are resolved in the same IDLE cycle by policy. Requests arriving during ADDR/DATA wait; masters hold arvalid per AXI.
- Throughput: one AR accepted per burst.
- Latency:
  - Master AR handshake to s_arvalid = 1 cycle.
  - Last beat to next possible grant = 1 cycle.

Test Plan:
- RR=0, m_arvalid=2'b11 in the same cycle, master1 addr 0x1FC0_0100 len 3 → m_arready=2'b10; s_araddr=0x1FC0_0100 and s_arlen=3 the next cycle; grant=1.
- RR=1, both masters request continuously over 4 single-beat bursts → grant sequence 0,1,0,1; every m_arready pulse is exactly one cycle.
- s_arready held low 5 cycles after s_arvalid → s_ar* stay constant; m_arready stays 0 for both masters; the DATA state is entered only after s_arready.
- len=3 burst with m_rready[grant] low on beat 2 for 3 cycles → s_rready low in those cycles; 4 beats delivered in order to the granted master only; return to IDLE; err_len=0.
- len=3 burst with s_rlast on beat 1 → err_len=1 (sticky); FSM returns to IDLE; a later clean burst leaves err_len=1 until areset.
- TIMEOUT=16, slave never asserts s_rvalid after AR → err_timeout=1 at the 16th idle DATA cycle; areset asserted mid-burst → next cycle is IDLE with all outputs at reset values.
